fetch_unit: RTL

Instruction-fetch stage that drives `pc_out`/`instruction` into the IF/ID pipeline register. Keeps the fetch PC, issues single-outstanding requests to instruction memory over a valid/ready handshake, and absorbs memory latency, decode stalls and branch redirects. Bubbles are presented as the all-zero instruction word, which the IF/ID register latches like any other word.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch stage, IF/ID register and hazard unit.
package pipeline_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] instr;
  } fetch_word_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_unit_if;
  import pipeline_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [PC_W-1:0] imem_rsp_data;

  modport master (output imem_req_valid, imem_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/fetch_unit.sv
// IF stage: single-outstanding imem fetch with one-entry skid buffer, stall hold
// and redirect kill of in-flight responses.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_INC   = 32'd4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] instruction,
  output logic            fetch_valid
);

  localparam fetch_word_t BUBBLE = '{pc: '0, instr: NOP_WORD};

  fetch_state_t    state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;
  logic            kill;
  fetch_word_t     buf_q;
  fetch_word_t     out_q;
  logic            out_vld;
  logic            hs;

  // Request side decodes registered state only.
  assign imem.imem_req_valid = (state == REQ);
  assign imem.imem_addr      = fetch_pc;
  assign hs                  = (state == REQ) && imem.imem_req_ready;

  assign pc_out      = out_q.pc;
  assign instruction = out_q.instr;
  assign fetch_valid = out_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      kill     <= 1'b0;
      buf_q    <= BUBBLE;
      out_q    <= BUBBLE;
      out_vld  <= 1'b0;
    end else begin
      if (!stall) begin
        out_q   <= BUBBLE;
        out_vld <= 1'b0;
      end
      case (state)
        REQ: if (hs) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + PC_INC;
          state    <= WAIT;
        end
        WAIT: if (imem.imem_rsp_valid) begin
          if (kill) begin
            kill  <= 1'b0;
            state <= REQ;
          end else if (!stall) begin
            out_q   <= '{pc: req_pc, instr: imem.imem_rsp_data};
            out_vld <= 1'b1;
            state   <= REQ;
          end else begin
            buf_q <= '{pc: req_pc, instr: imem.imem_rsp_data};
            state <= HOLD;
          end
        end
        HOLD: if (!stall) begin
          out_q   <= buf_q;
          out_vld <= 1'b1;
          state   <= REQ;
        end
        default: state <= REQ;
      endcase

      // Redirect overrides everything above, including a stall hold.
      if (redirect_valid) begin
        out_q    <= BUBBLE;
        out_vld  <= 1'b0;
        fetch_pc <= redirect_pc;
        case (state)
          REQ: if (hs) begin
            kill  <= 1'b1;
            state <= WAIT;
          end else begin
            state <= REQ;
          end
          WAIT: if (imem.imem_rsp_valid) begin
            kill  <= 1'b0;
            state <= REQ;
          end else begin
            kill  <= 1'b1;
          end
          default: begin
            buf_q <= BUBBLE;
            state <= REQ;
          end
        endcase
      end
    end
  end

endmodule
